// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 memory responder: default sizes,
// port-id encoding and the response pipeline stage record.
package mips32_mem_pkg;

    // Default geometry: 1024 words of 32 bits, word addressed.
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_AW         = 10;
    // Data grants allowed back-to-back while a fetch waits.
    localparam int DEF_STARVE_LIM = 2;

    // Which initiator a response belongs to.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // One slot of the two-stage response pipe.
    typedef struct packed {
        logic        valid;
        logic        port;
        logic [31:0] data;
        logic        err;
    } rsp_stage_t;

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Fetch/data arbiter for the single-port array. Data wins ties until it has
// taken STARVE_LIM grants in a row over a waiting fetch; then fetch is forced.
// Handshake: a request transfers when valid && ready at a rising edge; the
// grants below are the ready outputs and depend combinationally on the
// valids and the streak register. Grants are held low while in reset.
module mips32_mem_arbiter #(
    parameter int STARVE_LIM = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_valid_i,
    input  logic d_valid_i,
    output logic grant_if_o,
    output logic grant_d_o
);

    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    // Number of consecutive data grants taken while a fetch was pending.
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    // Grant selection and streak next-state.
    always_comb begin
        grant_d_o  = 1'b0;
        grant_if_o = 1'b0;
        streak_d   = '0;
        if (rst_ni) begin
            grant_d_o  = d_valid_i && (!if_valid_i || (streak_q < LIM));
            grant_if_o = if_valid_i && !grant_d_o;
        end
        // Streak only grows when data wins over a waiting fetch; a fetch
        // grant or an idle fetch port leaves it at zero.
        if (grant_d_o && if_valid_i) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Streak register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory-side responder: one single-port 32-bit array shared by instruction
// fetch and the load/store unit, fixed 2-cycle response latency.
// Requests use valid/ready (transfer on valid && ready at a rising edge);
// responses are valid-only one-cycle pulses with no backpressure.
module mips32_mem_responder
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = DEF_AW,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err
);

    logic [31:0] mem_q [DEPTH];

    logic        grant_if;
    logic        grant_d;
    logic        acc;
    logic        sel_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_data;

    rsp_stage_t st1_q;
    rsp_stage_t st2_q;

    mips32_mem_arbiter #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .if_valid_i (if_req_valid),
        .d_valid_i  (d_req_valid),
        .grant_if_o (grant_if),
        .grant_d_o  (grant_d)
    );

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    // Mux the granted request onto the array and range-check its address.
    always_comb begin
        acc      = (if_req_valid && grant_if) || (d_req_valid && grant_d);
        sel_port = grant_d ? PORT_D : PORT_IF;
        sel_addr = grant_d ? d_req_addr : if_req_addr;
        sel_we   = grant_d && d_req_we;
        in_range = (sel_addr[31:AW] == '0);
        idx      = sel_addr[AW-1:0];
        // Stores and out-of-range accesses return zero data.
        rd_data  = (!sel_we && in_range) ? mem_q[idx] : 32'h0;
    end

    // Array write at the accept edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (acc && sel_we && in_range) begin
            mem_q[idx] <= d_req_wdata;
        end
    end

    // Two-stage response pipe; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st1_q <= '0;
            st2_q <= '0;
        end else begin
            if (acc) begin
                st1_q.valid <= 1'b1;
                st1_q.port  <= sel_port;
                st1_q.data  <= rd_data;
                st1_q.err   <= !in_range;
            end else begin
                st1_q <= '0;
            end
            st2_q <= st1_q;
        end
    end

    // Steer the final stage to the owning port; other port sees zeros.
    always_comb begin
        if_rsp_valid = st2_q.valid && (st2_q.port == PORT_IF);
        d_rsp_valid  = st2_q.valid && (st2_q.port == PORT_D);
        if_rsp_data  = if_rsp_valid ? st2_q.data : 32'h0;
        d_rsp_data   = d_rsp_valid  ? st2_q.data : 32'h0;
        if_rsp_err   = if_rsp_valid && st2_q.err;
        d_rsp_err    = d_rsp_valid  && st2_q.err;
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder.
module tb_mips32_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_req_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_addr = '0;
    logic [31:0] d_req_wdata = '0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;

    mips32_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .d_rsp_err    (d_rsp_err)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Entry: {due_cycle[15:0], err, data[31:0]}
    localparam int W = 49;
    logic [W-1:0] if_q[$];
    logic [W-1:0] d_q[$];

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (if_rsp_valid === 1'b1) begin
            if (if_q.size() == 0) begin
                check("if_extra_pulse", 32'd1, 32'd0);
            end else begin
                e = if_q.pop_front();
                check("if_due", 32'(cyc), 32'(e[48:33]));
                check("if_data", if_rsp_data, e[31:0]);
                check("if_err", 32'(if_rsp_err), 32'(e[32]));
            end
        end else if (if_q.size() != 0) begin
            e = if_q[0];
            if (32'(e[48:33]) <= 32'(cyc)) begin
                void'(if_q.pop_front());
                check("if_missing_pulse", 32'd0, 32'd1);
            end
        end
        if (d_rsp_valid === 1'b1) begin
            if (d_q.size() == 0) begin
                check("d_extra_pulse", 32'd1, 32'd0);
            end else begin
                e = d_q.pop_front();
                check("d_due", 32'(cyc), 32'(e[48:33]));
                check("d_data", d_rsp_data, e[31:0]);
                check("d_err", 32'(d_rsp_err), 32'(e[32]));
            end
        end else if (d_q.size() != 0) begin
            e = d_q[0];
            if (32'(e[48:33]) <= 32'(cyc)) begin
                void'(d_q.pop_front());
                check("d_missing_pulse", 32'd0, 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present both ports for one cycle; record expectations for whatever is granted.
    task automatic drive(input logic ifv, input logic [31:0] ifa, input logic [31:0] if_exp,
                         input logic if_err_e, input logic dv, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic [31:0] d_exp, input logic d_err_e,
                         output logic gi, output logic gd);
        if_req_valid = ifv;
        if_req_addr  = ifa;
        d_req_valid  = dv;
        d_req_we     = dwe;
        d_req_addr   = da;
        d_req_wdata  = dwd;
        @(negedge clk);
        gi = if_req_valid & if_req_ready;
        gd = d_req_valid & d_req_ready;
        check("ready_exclusive", 32'(if_req_ready & d_req_ready), 32'd0);
        if (gi) if_q.push_back({16'(cyc + 2), if_err_e, if_exp});
        if (gd) d_q.push_back({16'(cyc + 2), d_err_e, d_exp});
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input logic err);
        logic gi, gd;
        drive(1'b1, a, exp, err, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, gi, gd);
        check("fetch_granted", 32'(gi), 32'd1);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic err);
        logic gi, gd;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, a, wd, 32'h0, err, gi, gd);
        check("store_granted", 32'(gd), 32'd1);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp, input logic err);
        logic gi, gd;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, a, 32'h0, exp, err, gi, gd);
        check("load_granted", 32'(gd), 32'd1);
    endtask

    task automatic idle(input int n);
        logic gi, gd;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, gi, gd);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_valid"}, 32'(if_rsp_valid), 32'd0);
        check({tag, "_if_data"},  if_rsp_data, 32'd0);
        check({tag, "_if_err"},   32'(if_rsp_err), 32'd0);
        check({tag, "_d_valid"},  32'(d_rsp_valid), 32'd0);
        check({tag, "_d_data"},   d_rsp_data, 32'd0);
        check({tag, "_d_err"},    32'(d_rsp_err), 32'd0);
        check({tag, "_streak"},   32'(dut.u_arb.streak_q), 32'd0);
    endtask

    // Hand-chosen preload pattern for words 0..15.
    function automatic logic [31:0] preload_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return {16'hC0DE, 16'(i)};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic gi, gd;
        logic exp_gd [9];
        logic [31:0] w;
        exp_gd = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset with both requests asserted: readies must stay low.
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_ready", 32'(if_req_ready), 32'd0);
        check("rst_d_ready",  32'(d_req_ready),  32'd0);
        check_quiet("rst");
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // Preload words 0..15 and word 1023 through the data port.
        for (int i = 0; i < 16; i++) store(32'(i), preload_word(i), 1'b0);
        store(32'd1023, 32'h0BADF00D, 1'b0);
        idle(3);

        // Single fetch: DEADBEEF exactly two cycles later, one pulse.
        fetch(32'd5, 32'hDEADBEEF, 1'b0);
        idle(4);

        // Store then load same address back to back (RAW).
        store(32'd7, 32'h12345678, 1'b0);
        load(32'd7, 32'h12345678, 1'b0);
        idle(4);

        // Both ports valid for 9 cycles: D,D,IF repeating.
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'd7, 32'h0,
                  32'h12345678, 1'b0, gi, gd);
            check("arb_grant_d",  32'(gd), 32'(exp_gd[k]));
            check("arb_grant_if", 32'(gi), 32'(!exp_gd[k]));
        end
        idle(4);

        // Out-of-range load and store; word 1023 must survive the store.
        load(32'h0000_0400, 32'h0, 1'b1);
        store(32'hFFFF_FFFF, 32'h55555555, 1'b1);
        load(32'd1023, 32'h0BADF00D, 1'b0);
        idle(4);

        // Cross-port RAW: store then fetch same word.
        store(32'd9, 32'hCAFEF00D, 1'b0);
        fetch(32'd9, 32'hCAFEF00D, 1'b0);
        idle(4);

        // Back-to-back fetches 0..15.
        for (int i = 0; i < 16; i++) begin
            w = preload_word(i);
            if (i == 7) w = 32'h12345678;
            if (i == 9) w = 32'hCAFEF00D;
            fetch(32'(i), w, 1'b0);
        end
        idle(4);

        // Reset right after a fetch is accepted: its response must vanish.
        fetch(32'd5, 32'hDEADBEEF, 1'b0);
        void'(if_q.pop_back());
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        @(negedge clk);
        check("mid_rst_if_ready", 32'(if_req_ready), 32'd0);
        check("mid_rst_d_ready",  32'(d_req_ready),  32'd0);
        @(posedge clk);
        #1;
        check_quiet("mid_rst");
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        rst_n = 1'b1;
        idle(5);

        // Recovery after reset.
        fetch(32'd0, 32'hC0DE0000, 1'b0);
        idle(4);

        check("if_queue_drained", 32'(if_q.size()), 32'd0);
        check("d_queue_drained",  32'(d_q.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips32_mem_responder.md
Name: mips32_mem_responder

Overview:
- Memory-side responder for the MIPS32 pipeline's two memory initiators: the instruction-fetch stage and the MEM-stage load/store unit.
- Holds a single-port, word-addressed 1024 x 32 array and arbitrates the two request streams onto it, one access per cycle.
- Returns read data and write acknowledges with a fixed 2-cycle latency.
- Replaces direct array indexing from inside the pipeline with a valid/ready request, valid-only response protocol.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- AW, 10, word-address width = log2(DEPTH).
- STARVE_LIM, 2, consecutive data grants allowed while a fetch is pending before fetch is forced.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req_valid  in  1  fetch request present.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  32  fetch word address (PC).
- if_rsp_valid  out  1  fetch response valid, one-cycle pulse.
- if_rsp_data  out  32  instruction word.
- if_rsp_err  out  1  fetch address out of range.
- d_req_valid  in  1  data request present.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  32  data word address (ALUout).
- d_req_wdata  in  32  store data.
- d_rsp_valid  out  1  data response or ack, one-cycle pulse.
- d_rsp_data  out  32  load data; 0 for stores.
- d_rsp_err  out  1  data address out of range.

Behaviour:
- Reset: clk and rst_n only; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - While rst_n = 0: all *_rsp_valid, *_rsp_err and *_req_ready are 0, *_rsp_data is 0, the streak counter is 0, and both pipeline stages are invalid.
  - Array contents are not reset.
  - Reset mid-operation discards every in-flight response; no response pulse appears for it after reset releases.
- Handshake:
  - A request transfers when valid && ready at a rising edge.
  - The ready outputs are combinational from the valids and the arbiter state.
  - At most one of if_req_ready and d_req_ready is 1 in any cycle.
  - Responses have no backpressure; the initiator must take them on the pulse.
- Arbiter (FSM on the streak counter, 0..STARVE_LIM):
  - Only one port valid: that port is granted.
  - Both valid, streak < STARVE_LIM: data is granted and streak increments.
  - Both valid, streak == STARVE_LIM: fetch is granted and streak clears.
  - Any fetch grant, or a cycle with no fetch pending, clears streak.
- Address check:
  - In range when addr[31:AW] == 0; the index is addr[AW-1:0].
  - Out-of-range read returns data 0 with err = 1.
  - Out-of-range write leaves the array untouched and acks with err = 1.
- Latency:
  - Cycle N: request accepted. The array read or write happens at edge N, and read data is captured into stage 1.
  - Stage 1 moves to stage 2 at edge N+1.
  - The response registers drive valid, data and err during cycle N+2.
  - Throughput is one accepted request per cycle, total across both ports.
- Ordering:
  - Responses per port are in acceptance order.
  - The write is committed at its accept edge, so a read accepted at N+1 to the same address returns the new data (read-after-write coherent). This applies across ports too: a fetch after a store sees the stored word.
- Simultaneous events: the response for an earlier request and the acceptance of a new request happen in the same cycle without interaction.
- Widths: no truncation of data; addresses truncate only to AW after the range check.

Decomposition:
- Shared package mips32_mem_pkg holds:
  - DEPTH and AW defaults.
  - The port-id encoding: PORT_IF = 1'b0, PORT_D = 1'b1.
  - The response-stage struct type: valid, port, data[31:0], err.
- Natural sub-module: mips32_mem_arbiter, containing the streak counter and the grant logic; its outputs are grant_if and grant_d.
- The array, address check and 2-stage response pipe remain in the top module.

Test Plan:
- Preload word 5 = 32'hDEADBEEF; fetch at addr 5 accepted at cycle 10 -> if_rsp_valid = 1 at cycle 12 with data 32'hDEADBEEF, err 0, and exactly one pulse.
- Store 32'h12345678 to addr 7 at cycle N, load addr 7 at N+1 -> store ack (d_rsp_valid, data 0) at N+2, load response 32'h12345678 at N+3.
- Both ports valid continuously for 9 cycles -> grant sequence D,D,IF,D,D,IF,D,D,IF; d_req_ready and if_req_ready are never high together.
- Load from addr 32'h0000_0400 -> d_rsp_err = 1 and data 0 two cycles later. Store to 32'hFFFF_FFFF -> err ack, and word 1023 is unchanged on a later read.
- Fetch accepted at cycle 20, rst_n = 0 at the cycle-21 edge for 1 cycle -> no if_rsp_valid at cycle 22 or later for that fetch; all outputs are 0 during reset.
- Back-to-back fetches of addrs 0..15, one per cycle -> 16 consecutive response pulses, in order, with data matching the preload.
